// File: rtl/texture_fetch_pkg.sv
// Shared FSM encoding and fetch/filter timing constants for the texture fetch sequencer.
package texture_fetch_pkg;

  localparam int COORD_WIDTH          = 16;
  localparam int FETCH_BILINEAR_READS = 4;
  localparam int FETCH_NEAREST_READS  = 1;
  localparam int FILTER_LATENCY       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/texel_addr_gen.sv
// Combinational 0.16 coordinate -> texel address/fraction mapping for the 2x2 footprint.
// Neighbour edge mode: TEXTURE_FETCH_CLAMP_EN defined = clamp-to-edge, otherwise repeat.
module texel_addr_gen
  import texture_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [COORD_WIDTH-1:0] tex_s,
  input  logic [COORD_WIDTH-1:0] tex_t,
  input  logic [3:0]             wlog2,
  input  logic [3:0]             hlog2,
  output logic [ADDR_WIDTH-1:0]  addr00,
  output logic [ADDR_WIDTH-1:0]  addr01,
  output logic [ADDR_WIDTH-1:0]  addr10,
  output logic [ADDR_WIDTH-1:0]  addr11,
  output logic [COORD_WIDTH-1:0] sub_s,
  output logic [COORD_WIDTH-1:0] sub_t
);

  logic [ADDR_WIDTH-1:0] x0, x1, y0, y1, xmask, ymask;
  logic [4:0]            shamt_x, shamt_y;

  always_comb begin
    shamt_x = 5'(COORD_WIDTH) - {1'b0, wlog2};
    shamt_y = 5'(COORD_WIDTH) - {1'b0, hlog2};
    xmask   = (ADDR_WIDTH'(1) << wlog2) - ADDR_WIDTH'(1);
    ymask   = (ADDR_WIDTH'(1) << hlog2) - ADDR_WIDTH'(1);
    x0      = ADDR_WIDTH'(tex_s >> shamt_x);
    y0      = ADDR_WIDTH'(tex_t >> shamt_y);
    // A 1-texel axis has no fractional position to interpolate across.
    sub_s   = (wlog2 == 4'd0) ? '0 : tex_s << wlog2;
    sub_t   = (hlog2 == 4'd0) ? '0 : tex_t << hlog2;
`ifdef TEXTURE_FETCH_CLAMP_EN
    x1      = (x0 == xmask) ? x0 : x0 + ADDR_WIDTH'(1);
    y1      = (y0 == ymask) ? y0 : y0 + ADDR_WIDTH'(1);
`else
    x1      = (x0 + ADDR_WIDTH'(1)) & xmask;
    y1      = (y0 + ADDR_WIDTH'(1)) & ymask;
`endif
    addr00  = (y0 << wlog2) | x0;
    addr01  = (y0 << wlog2) | x1;
    addr10  = (y1 << wlog2) | x0;
    addr11  = (y1 << wlog2) | x1;
  end

endmodule

// File: rtl/texture_fetch_sequencer.sv
// Sequences 4 (bilinear) or 1 (nearest) texel reads per sample; ISSUE at accept+6/+3, out_valid 4 cycles later.
// s_ready only in IDLE, no request buffering; neighbour edge mode selected by TEXTURE_FETCH_CLAMP_EN.
module texture_fetch_sequencer
  import texture_fetch_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [15:0]            s_texS,
  input  logic [15:0]            s_texT,
  input  logic                   s_filter,
  input  logic [3:0]             cfg_wlog2,
  input  logic [3:0]             cfg_hlog2,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic [PIXEL_WIDTH-1:0] f_texel00,
  output logic [PIXEL_WIDTH-1:0] f_texel01,
  output logic [PIXEL_WIDTH-1:0] f_texel10,
  output logic [PIXEL_WIDTH-1:0] f_texel11,
  output logic [15:0]            f_subS,
  output logic [15:0]            f_subT,
  output logic                   f_enable,
  output logic                   out_valid
);

  state_t                    state, state_nxt;
  logic [2:0]                cnt, cnt_last;
  logic                      filt_q, accept, cap_vld;
  logic [1:0]                cap_idx;
  logic [ADDR_WIDTH-1:0]     addr_q [4];
  logic [ADDR_WIDTH-1:0]     a00, a01, a10, a11;
  logic [15:0]               sub_s, sub_t;
  logic [FILTER_LATENCY-1:0] vld_sr, flt_sr;

  texel_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .tex_s  (s_texS),
    .tex_t  (s_texT),
    .wlog2  (cfg_wlog2),
    .hlog2  (cfg_hlog2),
    .addr00 (a00),
    .addr01 (a01),
    .addr10 (a10),
    .addr11 (a11),
    .sub_s  (sub_s),
    .sub_t  (sub_t)
  );

  assign accept   = s_valid & s_ready;
  assign cnt_last = filt_q ? 3'(FETCH_BILINEAR_READS) : 3'(FETCH_NEAREST_READS);

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FETCH ends with one read-free cycle in which the last read data is captured.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      ST_IDLE: begin
        s_ready = ~reset;
        if (s_valid && !reset) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (cnt == cnt_last) begin
          state_nxt = ST_ISSUE;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = addr_q[cnt[1:0]];
        end
      end
      ST_ISSUE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      filt_q    <= 1'b0;
      addr_q    <= '{default: '0};
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      f_subS    <= '0;
      f_subT    <= '0;
      f_texel00 <= '0;
      f_texel01 <= '0;
      f_texel10 <= '0;
      f_texel11 <= '0;
      vld_sr    <= '0;
      flt_sr    <= '0;
    end else begin
      cap_vld <= mem_rd;
      cap_idx <= cnt[1:0];
      vld_sr  <= {vld_sr[FILTER_LATENCY-2:0], state == ST_ISSUE};
      flt_sr  <= {flt_sr[FILTER_LATENCY-2:0], (state == ST_ISSUE) & filt_q};
      if (accept) begin
        cnt       <= '0;
        filt_q    <= s_filter;
        addr_q[0] <= a00;
        addr_q[1] <= a01;
        addr_q[2] <= a10;
        addr_q[3] <= a11;
        f_subS    <= s_filter ? sub_s : '0;
        f_subT    <= s_filter ? sub_t : '0;
      end else if (mem_rd) begin
        cnt <= cnt + 3'd1;
      end
      if (cap_vld) begin
        case (cap_idx)
          2'd0: begin
            f_texel00 <= mem_rdata;
            // Nearest sampling replicates the single texel across the footprint.
            if (!filt_q) begin
              f_texel01 <= mem_rdata;
              f_texel10 <= mem_rdata;
              f_texel11 <= mem_rdata;
            end
          end
          2'd1:    f_texel01 <= mem_rdata;
          2'd2:    f_texel10 <= mem_rdata;
          default: f_texel11 <= mem_rdata;
        endcase
      end
    end
  end

  assign out_valid = vld_sr[FILTER_LATENCY-1];
  assign f_enable  = flt_sr[FILTER_LATENCY-1];

endmodule

// File: tb/tb_texture_fetch_sequencer.sv
// Bench for texture_fetch_sequencer: directed vector table, randomized samples against an
// arithmetic reference model, plus back-to-back and mid-fetch reset sequences.
module tb_texture_fetch_sequencer;

  logic        aclk, reset, s_valid, s_ready, s_filter;
  logic [15:0] s_texS, s_texT;
  logic [3:0]  cfg_wlog2, cfg_hlog2;
  logic        mem_rd, f_enable, out_valid;
  logic [15:0] mem_addr, mem_rdata;
  logic [15:0] f_texel00, f_texel01, f_texel10, f_texel11, f_subS, f_subT;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  texture_fetch_sequencer #(.PIXEL_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .aclk(aclk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_texS(s_texS), .s_texT(s_texT), .s_filter(s_filter),
    .cfg_wlog2(cfg_wlog2), .cfg_hlog2(cfg_hlog2),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .f_texel00(f_texel00), .f_texel01(f_texel01), .f_texel10(f_texel10), .f_texel11(f_texel11),
    .f_subS(f_subS), .f_subT(f_subT), .f_enable(f_enable), .out_valid(out_valid)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // Texel memory: every address holds a distinct value; idle reads return junk.
  function automatic logic [15:0] texval(input logic [15:0] a);
    return a * 16'd40503 + 16'h1357;
  endfunction

  always @(posedge aclk) mem_rdata <= mem_rd ? texval(mem_addr) : 16'hDEAD;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] pk4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference: positions as coordinate * size / 65536, addresses as y*width + x.
  task automatic model(input logic [15:0] ts, tt, input logic flt, input logic [3:0] wl, hl,
                       output int nrd, output logic [3:0][15:0] ea,
                       output logic [15:0] es, et, output int eov);
    int w, h, sx, sy, x0, x1, y0, y1;
    w  = 1 << wl;
    h  = 1 << hl;
    sx = int'(ts) * w;
    sy = int'(tt) * h;
    x0 = sx / 65536;
    y0 = sy / 65536;
`ifdef TEXTURE_FETCH_CLAMP_EN
    x1 = (x0 + 1 < w) ? x0 + 1 : w - 1;
    y1 = (y0 + 1 < h) ? y0 + 1 : h - 1;
`else
    x1 = (x0 + 1) % w;
    y1 = (y0 + 1) % h;
`endif
    ea  = pk4(16'(y0 * w + x0), 16'(y0 * w + x1), 16'(y1 * w + x0), 16'(y1 * w + x1));
    es  = (flt && wl != 0) ? 16'(sx % 65536) : 16'h0;
    et  = (flt && hl != 0) ? 16'(sy % 65536) : 16'h0;
    nrd = flt ? 4 : 1;
    eov = flt ? 10 : 7;
  endtask

  task automatic run_sample(input logic [15:0] ts, tt, input logic flt, input logic [3:0] wl, hl,
                            input int nrd, input logic [3:0][15:0] ea,
                            input logic [15:0] es, et, input int eov, input string nm);
    int acc, rd_n, ov_n, ov_rel, waitc;
    int gc[4];
    logic [3:0][15:0] ga;
    logic [15:0] t00, t01, t10, t11, gs, gt;
    logic gen;
    cfg_wlog2 = wl; cfg_hlog2 = hl;
    s_texS = ts; s_texT = tt; s_filter = flt; s_valid = 1'b1;
    waitc = 0;
    while (!s_ready && waitc < 20) begin
      @(negedge aclk);
      waitc++;
    end
    check({nm, " s_ready"}, 32'(s_ready), 32'd1);
    acc = cyc;
    @(negedge aclk);
    s_valid = 1'b0;
    rd_n = 0; ov_n = 0; ov_rel = -1; ga = '0; gc = '{default: -1};
    t00 = '0; t01 = '0; t10 = '0; t11 = '0; gs = '0; gt = '0; gen = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (mem_rd) begin
        if (rd_n < 4) begin
          ga[rd_n] = mem_addr;
          gc[rd_n] = cyc - acc;
        end
        rd_n++;
      end
      if (out_valid) begin
        ov_n++;
        ov_rel = cyc - acc;
        t00 = f_texel00; t01 = f_texel01; t10 = f_texel10; t11 = f_texel11;
        gs = f_subS; gt = f_subT; gen = f_enable;
      end
      @(negedge aclk);
    end
    check({nm, " read count"}, 32'(rd_n), 32'(nrd));
    for (int i = 0; i < nrd; i++) begin
      check($sformatf("%s addr%0d", nm, i), 32'(ga[i]), 32'(ea[i]));
      check($sformatf("%s read%0d cycle", nm, i), 32'(gc[i]), 32'(i + 1));
    end
    check({nm, " out_valid count"}, 32'(ov_n), 32'd1);
    check({nm, " out_valid cycle"}, 32'(ov_rel), 32'(eov));
    check({nm, " texel00"}, 32'(t00), 32'(texval(ea[0])));
    check({nm, " texel01"}, 32'(t01), 32'(texval(flt ? ea[1] : ea[0])));
    check({nm, " texel10"}, 32'(t10), 32'(texval(flt ? ea[2] : ea[0])));
    check({nm, " texel11"}, 32'(t11), 32'(texval(flt ? ea[3] : ea[0])));
    check({nm, " subS"}, 32'(gs), 32'(es));
    check({nm, " subT"}, 32'(gt), 32'(et));
    check({nm, " f_enable"}, 32'(gen), 32'(flt));
  endtask

  typedef struct {
    logic [15:0]      ts, tt;
    logic             flt;
    logic [3:0]       wl, hl;
    int               nrd;
    logic [3:0][15:0] ea;
    logic [15:0]      es, et;
    int               eov;
    string            nm;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int               nrd, eov, nacc, nov;
    int               acc_q[$], ov_q[$];
    logic [3:0][15:0] ea;
    logic [15:0]      es, et, ts, tt;
    logic             flt;
    logic [3:0]       wl, hl;

    tbl[0] = '{16'h1800, 16'h2400, 1'b1, 4'd4, 4'd4, 4, pk4(16'h21, 16'h22, 16'h31, 16'h32),
               16'h8000, 16'h4000, 10, "bilinear16"};
    tbl[1] = '{16'h1800, 16'h2400, 1'b0, 4'd4, 4'd4, 1, pk4(16'h21, 16'h21, 16'h21, 16'h21),
               16'h0000, 16'h0000, 7, "nearest16"};
`ifdef TEXTURE_FETCH_CLAMP_EN
    tbl[2] = '{16'hFF00, 16'h0000, 1'b1, 4'd4, 4'd4, 4, pk4(16'h0F, 16'h0F, 16'h1F, 16'h1F),
               16'hF000, 16'h0000, 10, "edge16"};
    tbl[4] = '{16'hFFFF, 16'h8080, 1'b1, 4'd8, 4'd8, 4, pk4(16'h80FF, 16'h80FF, 16'h81FF, 16'h81FF),
               16'hFF00, 16'h8000, 10, "edge256"};
`else
    tbl[2] = '{16'hFF00, 16'h0000, 1'b1, 4'd4, 4'd4, 4, pk4(16'h0F, 16'h00, 16'h1F, 16'h10),
               16'hF000, 16'h0000, 10, "edge16"};
    tbl[4] = '{16'hFFFF, 16'h8080, 1'b1, 4'd8, 4'd8, 4, pk4(16'h80FF, 16'h8000, 16'h81FF, 16'h8100),
               16'hFF00, 16'h8000, 10, "edge256"};
`endif
    tbl[3] = '{16'hABCD, 16'h1234, 1'b1, 4'd0, 4'd0, 4, pk4(16'h0, 16'h0, 16'h0, 16'h0),
               16'h0000, 16'h0000, 10, "size1x1"};

    reset = 1'b1; s_valid = 1'b0; s_filter = 1'b0; s_texS = '0; s_texT = '0;
    cfg_wlog2 = 4'd4; cfg_hlog2 = 4'd4;
    repeat (3) @(negedge aclk);
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset mem_rd", 32'(mem_rd), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset f_enable", 32'(f_enable), 32'd0);
    check("reset texels", {f_texel00 | f_texel01, f_texel10 | f_texel11}, 32'd0);
    check("reset subs", {f_subS, f_subT}, 32'd0);
    reset = 1'b0;
    @(negedge aclk);
    check("post-reset s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 5; i++)
      run_sample(tbl[i].ts, tbl[i].tt, tbl[i].flt, tbl[i].wl, tbl[i].hl, tbl[i].nrd, tbl[i].ea,
                 tbl[i].es, tbl[i].et, tbl[i].eov, tbl[i].nm);

    for (int i = 0; i < 24; i++) begin
      ts  = 16'($urandom);
      tt  = 16'($urandom);
      flt = 1'($urandom_range(0, 1));
      wl  = 4'($urandom_range(0, 8));
      hl  = 4'($urandom_range(0, 8));
      model(ts, tt, flt, wl, hl, nrd, ea, es, et, eov);
      run_sample(ts, tt, flt, wl, hl, nrd, ea, es, et, eov, $sformatf("rand%0d", i));
    end

    // Back-to-back: three filtered samples with s_valid held high.
    cfg_wlog2 = 4'd4; cfg_hlog2 = 4'd4;
    s_texS = 16'h1800; s_texT = 16'h2400; s_filter = 1'b1; s_valid = 1'b1;
    nacc = cyc;
    for (int k = 0; k < 30; k++) begin
      if (s_valid && s_ready) acc_q.push_back(cyc - nacc);
      if (out_valid) ov_q.push_back(cyc - nacc);
      @(negedge aclk);
      if (acc_q.size() == 3) s_valid = 1'b0;
    end
    check("b2b accept count", 32'(acc_q.size()), 32'd3);
    check("b2b out_valid count", 32'(ov_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b accept%0d cycle", i), (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFFFFFF,
            32'(7 * i));
      check($sformatf("b2b out_valid%0d cycle", i), (i < ov_q.size()) ? 32'(ov_q[i]) : 32'hFFFFFFFF,
            32'(7 * i + 10));
    end

    // Reset asserted in cycle 3 of a filtered fetch.
    s_valid = 1'b1;
    check("rst-test s_ready", 32'(s_ready), 32'd1);
    @(negedge aclk);
    s_valid = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst-test texel00 before reset", 32'(f_texel00), 32'(texval(16'h21)));
    reset = 1'b1;
    #1;
    check("async reset mem_rd", 32'(mem_rd), 32'd0);
    check("async reset s_ready", 32'(s_ready), 32'd0);
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset f_enable", 32'(f_enable), 32'd0);
    check("async reset texel00", 32'(f_texel00), 32'd0);
    check("async reset subs", {f_subS, f_subT}, 32'd0);
    @(negedge aclk);
    reset = 1'b0;
    #1;
    check("after release s_ready", 32'(s_ready), 32'd1);
    nov = 0; nrd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (out_valid) nov++;
      if (mem_rd) nrd++;
    end
    check("dropped sample out_valid", 32'(nov), 32'd0);
    check("dropped sample mem_rd", 32'(nrd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
